// File: rtl/merge_serialize4_pkg.sv
// merge_serialize4_pkg: shared widths, lane count and FSM states for the merge/serialize block.
package merge_serialize4_pkg;
   localparam int ADDRW_DEF = 16;
   localparam int WL_DEF    = 32;
   localparam int LANES     = 4;
   typedef enum logic {IDLE, EMIT} state_t;
endpackage

// File: rtl/merge_reduce4.sv
// merge_reduce4: combinational head detection and per-index value summing across four lanes.
module merge_reduce4
   import merge_serialize4_pkg::*;
#(
   parameter int ADDRW = ADDRW_DEF,
   parameter int WL    = WL_DEF
)(
   input  logic [LANES-1:0]           valid,
   input  logic [LANES-1:0][ADDRW-1:0] index,
   input  logic [LANES-1:0][WL-1:0]    value,
   output logic [LANES-1:0]           head,
   output logic [LANES-1:0][WL-1:0]    sum,
   output logic [2:0]                 head_cnt,
   output logic [2:0]                 valid_cnt
);
   // A lane is a head unless an earlier valid lane carries the same index.
   always_comb begin
      head      = '0;
      sum       = '0;
      head_cnt  = '0;
      valid_cnt = '0;
      for (int i = 0; i < LANES; i++) begin
         head[i] = valid[i];
         for (int j = 0; j < LANES; j++)
            if (valid[j] && index[j] == index[i]) begin
               sum[i] = sum[i] + value[j];
               if (j < i) head[i] = 1'b0;
            end
         head_cnt  = head_cnt + 3'(head[i]);
         valid_cnt = valid_cnt + 3'(valid[i]);
      end
   end
endmodule

// File: rtl/merge_serialize4.sv
// merge_serialize4: merges duplicate-index lanes of a 4-lane group and emits the
// distinct entries one per handshake, counting merged-away lanes in dup_cnt.
module merge_serialize4
   import merge_serialize4_pkg::*;
#(
   parameter int ADDRW = ADDRW_DEF,
   parameter int WL    = WL_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             valid1,
   input  logic             valid2,
   input  logic             valid3,
   input  logic             valid4,
   input  logic [ADDRW-1:0] index1,
   input  logic [ADDRW-1:0] index2,
   input  logic [ADDRW-1:0] index3,
   input  logic [ADDRW-1:0] index4,
   input  logic [WL-1:0]    value1,
   input  logic [WL-1:0]    value2,
   input  logic [WL-1:0]    value3,
   input  logic [WL-1:0]    value4,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ADDRW-1:0] out_index,
   output logic [WL-1:0]    out_value,
   output logic             out_last,
   output logic [31:0]      dup_cnt
);
   state_t                     state, state_n;
   logic [LANES-1:0]           valid, head, mask, rest;
   logic [LANES-1:0][ADDRW-1:0] index, idx_r;
   logic [LANES-1:0][WL-1:0]    value, sum, sum_r;
   logic [2:0]                 head_cnt, valid_cnt;
   logic [1:0]                 sel;
   logic [32:0]                dup_sum;
   logic                       accept, fire;

   assign valid = {valid4, valid3, valid2, valid1};
   assign index = {index4, index3, index2, index1};
   assign value = {value4, value3, value2, value1};

   merge_reduce4 #(.ADDRW(ADDRW), .WL(WL)) u_reduce (
      .valid(valid), .index(index), .value(value),
      .head(head), .sum(sum), .head_cnt(head_cnt), .valid_cnt(valid_cnt)
   );

   always_comb begin
      in_ready  = state == IDLE;
      out_valid = state == EMIT;
      accept    = ena && in_ready;
      fire      = out_valid && out_ready;
      rest      = mask & (mask - 4'd1);
      sel       = mask[0] ? 2'd0 : mask[1] ? 2'd1 : mask[2] ? 2'd2 : 2'd3;
      out_index = out_valid ? idx_r[sel] : '0;
      out_value = out_valid ? sum_r[sel] : '0;
      out_last  = out_valid && rest == '0;
      dup_sum   = {1'b0, dup_cnt} + 33'(valid_cnt - head_cnt);
      state_n   = state;
      if (accept && head != '0) state_n = EMIT;
      if (fire && out_last) state_n = IDLE;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= IDLE;
         mask    <= '0;
         idx_r   <= '0;
         sum_r   <= '0;
         dup_cnt <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            mask    <= head;
            idx_r   <= index;
            sum_r   <= sum;
            dup_cnt <= dup_sum[32] ? '1 : dup_sum[31:0];
         end else if (fire)
            mask <= rest;
      end
endmodule

// File: tb/tb_merge_serialize4.sv
// tb_merge_serialize4: directed and random groups checked against a queue-based merge model.
module tb_merge_serialize4;
   typedef struct {logic [15:0] i; logic [31:0] v; logic l;} ent_t;

   logic        clk, rst, ena, out_ready;
   logic [3:0]  v;
   logic [15:0] ix [4];
   logic [31:0] vl [4];
   logic        in_ready, out_valid, out_last;
   logic [15:0] out_index;
   logic [31:0] out_value, dup_cnt;

   int     n_chk = 0, n_fail = 0;
   ent_t   q[$], g[$];
   longint dup_m = 0;
   bit     idle, f;
   int     nv;

   merge_serialize4 dut (
      .clk(clk), .rst(rst), .ena(ena),
      .valid1(v[0]), .valid2(v[1]), .valid3(v[2]), .valid4(v[3]),
      .index1(ix[0]), .index2(ix[1]), .index3(ix[2]), .index4(ix[3]),
      .value1(vl[0]), .value2(vl[1]), .value3(vl[2]), .value4(vl[3]),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_index(out_index), .out_value(out_value), .out_last(out_last),
      .dup_cnt(dup_cnt)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: distinct valid indices in first-appearance order, each with the wrapped sum of its lanes.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         q.delete();
         dup_m = 0;
      end else begin
         idle = q.size() == 0;
         check("in_ready", in_ready, idle);
         check("out_valid", out_valid, !idle);
         if (!idle && out_valid) begin
            check("out_index", out_index, q[0].i);
            check("out_value", out_value, q[0].v);
            check("out_last", out_last, q[0].l);
            if (out_ready) void'(q.pop_front());
         end
         check("dup_cnt", dup_cnt, dup_m);
         if (ena && idle) begin
            g.delete();
            nv = 0;
            for (int i = 0; i < 4; i++)
               if (v[i]) begin
                  nv++;
                  f = 0;
                  foreach (g[k])
                     if (g[k].i == ix[i]) begin
                        g[k].v = g[k].v + vl[i];
                        f = 1;
                     end
                  if (!f) g.push_back('{ix[i], vl[i], 1'b0});
               end
            if (g.size() > 0) g[g.size()-1].l = 1'b1;
            foreach (g[k]) q.push_back(g[k]);
            dup_m = dup_m + nv - g.size();
            if (dup_m > 64'hFFFF_FFFF) dup_m = 64'hFFFF_FFFF;
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check("idle_timeout", 0, 1);
   endtask

   task automatic send(input logic [3:0] vv, input logic [3:0][15:0] a, input logic [3:0][31:0] d);
      wait_idle();
      v = vv;
      for (int i = 0; i < 4; i++) begin
         ix[i] = a[i];
         vl[i] = d[i];
      end
      ena = 1;
      @(posedge clk); #1;
      ena = 0;
      v = 0;
   endtask

   task automatic entry(input string nm, input logic [15:0] ei, input logic [31:0] ev, input logic el);
      check({nm, "_valid"}, out_valid, 1);
      check({nm, "_index"}, out_index, ei);
      check({nm, "_value"}, out_value, ev);
      check({nm, "_last"}, out_last, el);
   endtask

   task automatic run_basic(input logic [31:0] dup_exp);
      out_ready = 1;
      send(4'hf, {16'd9, 16'd7, 16'd5, 16'd5}, {32'd2, 32'd1, 32'd20, 32'd10});
      @(negedge clk); entry("basic0", 5, 30, 0);
      @(negedge clk); entry("basic1", 7, 1, 0);
      @(negedge clk); entry("basic2", 9, 2, 1);
      check("basic_dup", dup_cnt, dup_exp);
      @(negedge clk);
      check("basic_bubble_valid", out_valid, 0);
      check("basic_bubble_ready", in_ready, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1; ena = 0; out_ready = 1; v = 0;
      for (int i = 0; i < 4; i++) begin ix[i] = 0; vl[i] = 0; end
      #3;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_index", out_index, 0);
      check("rst_out_value", out_value, 0);
      check("rst_dup", dup_cnt, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 0;
      check("rst_in_ready", in_ready, 1);

      run_basic(1);

      send(4'hf, {16'd3, 16'd3, 16'd3, 16'd3}, {32'd3, 32'd2, 32'd1, 32'hFFFF_FFFF});
      @(negedge clk); entry("wrap", 3, 5, 1);
      check("wrap_dup", dup_cnt, 4);
      @(posedge clk); #1;

      send(4'b1010, {16'd8, 16'd4, 16'd8, 16'd4}, {32'd7, 32'hDEAD, 32'd6, 32'hBEEF});
      @(negedge clk); entry("inval", 8, 13, 1);
      check("inval_dup", dup_cnt, 5);
      @(posedge clk); #1;

      out_ready = 0;
      send(4'hf, {16'd30, 16'd20, 16'd10, 16'd10}, {32'd4, 32'd3, 32'd2, 32'd1});
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         entry("stall", 10, 3, 0);
         check("stall_in_ready", in_ready, 0);
         @(posedge clk); #1;
         ena = 1; v = 4'hf; ix[0] = 16'd77; vl[0] = 32'd99;
      end
      ena = 0; v = 0;
      out_ready = 1;
      @(negedge clk); entry("stall_rel", 10, 3, 0);
      @(posedge clk); #1;
      wait_idle();

      send(4'h0, {16'd1, 16'd1, 16'd1, 16'd1}, {32'd1, 32'd1, 32'd1, 32'd1});
      @(negedge clk);
      check("empty_valid", out_valid, 0);
      check("empty_ready", in_ready, 1);
      @(posedge clk); #1;

      send(4'hf, {16'd40, 16'd30, 16'd20, 16'd10}, {32'd4, 32'd3, 32'd2, 32'd1});
      @(negedge clk); entry("rst_e0", 10, 1, 0);
      @(negedge clk); entry("rst_e1", 20, 2, 0);
      #2 rst = 1;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_last", out_last, 0);
      check("midrst_dup", dup_cnt, 0);
      check("midrst_ready", in_ready, 1);
      @(posedge clk); @(posedge clk); #1;
      rst = 0;
      run_basic(1);

      for (int c = 0; c < 500; c++) begin
         out_ready = $urandom_range(0, 3) != 0;
         ena = $urandom_range(0, 1) == 1;
         v = 4'($urandom);
         for (int i = 0; i < 4; i++) begin
            ix[i] = 16'($urandom_range(0, 3));
            vl[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
         end
         @(posedge clk); #1;
      end
      ena = 0; v = 0; out_ready = 1;
      wait_idle();
      @(negedge clk);
      check("final_queue_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
